bmp_write_scheduler: RTL and testbench

Sequences the pixel-pair write path into the output BMP frame buffer. Accepts thresholded even/odd pixel pairs from the upstream datapath through a valid/ready handshake. For each accepted pair it generates the byte address and write strobe for the frame-buffer writer, and drives the horizontal synchronous pulse. It flags frame completion to the file-dump stage.

---
 rtl/bmp_write_scheduler_pkg.sv | 35 +++
 rtl/bmp_write_scheduler_if.sv | 39 +++
 rtl/bmp_write_scheduler_addr_gen.sv | 46 ++++
 rtl/bmp_write_scheduler.sv | 162 ++++++++++++++++
 tb/tb_bmp_write_scheduler.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/bmp_write_scheduler_pkg.sv
// Shared types and constants for the BMP pixel-pair write scheduler.
// Widths are sized for the default 768x512 geometry.
package bmp_write_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ACTIVE   = 2'd1,
        ST_LINE_GAP = 2'd2,
        ST_DONE     = 2'd3
    } sched_state_e;

    localparam int BMP_HEADER_NUMBER = 54;
    localparam int BYTES_PER_PIXEL   = 3;

    localparam int DEF_IMAGE_WIDTH  = 768;
    localparam int DEF_IMAGE_HEIGHT = 512;

    localparam int ADDR_W = $clog2(DEF_IMAGE_WIDTH * DEF_IMAGE_HEIGHT * BYTES_PER_PIXEL);
    localparam int PAIR_W = 19;
    localparam int ROW_W  = $clog2(DEF_IMAGE_HEIGHT);
    localparam int COL_W  = $clog2(DEF_IMAGE_WIDTH / 2);
    localparam int GAP_W  = 16;

    // Byte offset of the even pixel of pair 'col' in buffer row 'row_idx'.
    function automatic logic [ADDR_W-1:0] pixel_addr(
        input logic [ROW_W-1:0]  row_idx,
        input logic [COL_W-1:0]  col,
        input logic [ADDR_W-1:0] width
    );
        logic [ADDR_W-1:0] pix_s;
        pix_s      = ADDR_W'(row_idx) * width + ADDR_W'({col, 1'b0});
        pixel_addr = pix_s * ADDR_W'(BYTES_PER_PIXEL);
    endfunction

endpackage

// File: rtl/bmp_write_scheduler_if.sv
// Pixel-pair handshake and frame-buffer write bus of the BMP write scheduler.
// The master side is the upstream datapath / file-dump environment.
interface bmp_write_scheduler_if
    import bmp_write_scheduler_pkg::*;
();
    logic              start;
    logic              in_Valid;
    logic              in_Ready;
    logic              horizontal_Pulse;
    logic              wr_En;
    logic [ADDR_W-1:0] wr_Addr;
    logic [PAIR_W-1:0] pair_Counter;
    logic              busy;
    logic              sig_Write_Done;

    modport master (
        output start,
        output in_Valid,
        input  in_Ready,
        input  horizontal_Pulse,
        input  wr_En,
        input  wr_Addr,
        input  pair_Counter,
        input  busy,
        input  sig_Write_Done
    );

    modport slave (
        input  start,
        input  in_Valid,
        output in_Ready,
        output horizontal_Pulse,
        output wr_En,
        output wr_Addr,
        output pair_Counter,
        output busy,
        output sig_Write_Done
    );
endinterface

// File: rtl/bmp_write_scheduler_addr_gen.sv
// bmp_addr_gen: registered row/col to frame-buffer byte-address generator.
// BMP_ROW_FLIP_EN selects bottom-up (BMP) row order; undefined gives top-down.
module bmp_addr_gen
    import bmp_write_scheduler_pkg::*;
#(
    parameter int IMAGE_WIDTH  = 768,
    parameter int IMAGE_HEIGHT = 512
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pair_accept,
    input  logic [ROW_W-1:0]  row,
    input  logic [COL_W-1:0]  col,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr
);
    logic [ROW_W-1:0]  row_idx_s;
    logic [ADDR_W-1:0] addr_s;
    logic              wr_en_r;
    logic [ADDR_W-1:0] wr_addr_r;

`ifdef BMP_ROW_FLIP_EN
    assign row_idx_s = ROW_W'(IMAGE_HEIGHT - 1) - row;
`else
    assign row_idx_s = row;
`endif

    assign addr_s = pixel_addr(row_idx_s, col, ADDR_W'(IMAGE_WIDTH));

    // Write strobe follows the handshake by one cycle; the address holds between writes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_en_r   <= 1'b0;
            wr_addr_r <= {ADDR_W{1'b0}};
        end else if (pair_accept) begin
            wr_en_r   <= 1'b1;
            wr_addr_r <= addr_s;
        end else begin
            wr_en_r   <= 1'b0;
        end
    end

    assign wr_en   = wr_en_r;
    assign wr_addr = wr_addr_r;

endmodule

// File: rtl/bmp_write_scheduler.sv
// bmp_write_scheduler: accepts pixel pairs row by row, emits frame-buffer writes,
// inserts HBLANK idle cycles between rows and pulses done at frame end (BMP_ROW_FLIP_EN in bmp_addr_gen).
module bmp_write_scheduler
    import bmp_write_scheduler_pkg::*;
#(
    parameter int IMAGE_WIDTH  = 768,
    parameter int IMAGE_HEIGHT = 512,
    parameter int HBLANK       = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    bmp_write_scheduler_if.slave bus
);
    sched_state_e      state_r;
    sched_state_e      next_state_s;
    logic [ROW_W-1:0]  row_r;
    logic [COL_W-1:0]  col_r;
    logic [GAP_W-1:0]  gap_cnt_r;
    logic [PAIR_W-1:0] pair_cnt_r;
    logic              busy_r;
    logic              done_r;
    logic              in_ready_r;
    logic              hpulse_r;
    logic              in_ready_s;
    logic              hpulse_s;
    logic              hs_s;
    logic              last_col_s;
    logic              last_row_s;
    logic              gap_end_s;
    logic              start_ok_s;
    logic              wr_en_s;
    logic [ADDR_W-1:0] wr_addr_s;

    assign hs_s       = bus.in_Valid & in_ready_r;
    assign last_col_s = (col_r == COL_W'(IMAGE_WIDTH / 2 - 1));
    assign last_row_s = (row_r == ROW_W'(IMAGE_HEIGHT - 1));
    assign gap_end_s  = (gap_cnt_r == GAP_W'(HBLANK - 1));
    // done_r marks the cycle right after DONE; a start there belongs to the old frame.
    assign start_ok_s = bus.start & ~done_r;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_ok_s) next_state_s = ST_ACTIVE;
                else            next_state_s = ST_IDLE;
            end
            ST_ACTIVE: begin
                if (hs_s && last_col_s) begin
                    if (last_row_s) next_state_s = ST_DONE;
                    else            next_state_s = ST_LINE_GAP;
                end else begin
                    next_state_s = ST_ACTIVE;
                end
            end
            ST_LINE_GAP: begin
                if (gap_end_s) next_state_s = ST_ACTIVE;
                else           next_state_s = ST_LINE_GAP;
            end
            ST_DONE:  next_state_s = ST_IDLE;
            default:  next_state_s = ST_IDLE;
        endcase
    end

    // Moore outputs decoded from the upcoming state so they can be registered.
    always_comb begin
        in_ready_s = 1'b0;
        hpulse_s   = 1'b0;
        case (next_state_s)
            ST_ACTIVE: begin
                in_ready_s = 1'b1;
                hpulse_s   = 1'b1;
            end
            default: begin
                in_ready_s = 1'b0;
                hpulse_s   = 1'b0;
            end
        endcase
    end

    // Output registers for the Moore outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_ready_r <= 1'b0;
            hpulse_r   <= 1'b0;
        end else begin
            in_ready_r <= in_ready_s;
            hpulse_r   <= hpulse_s;
        end
    end

    // Row/column/gap/pair counters plus busy and done flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row_r      <= {ROW_W{1'b0}};
            col_r      <= {COL_W{1'b0}};
            gap_cnt_r  <= {GAP_W{1'b0}};
            pair_cnt_r <= {PAIR_W{1'b0}};
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            done_r <= (state_r == ST_DONE);
            case (state_r)
                ST_IDLE: begin
                    if (start_ok_s) begin
                        row_r      <= {ROW_W{1'b0}};
                        col_r      <= {COL_W{1'b0}};
                        pair_cnt_r <= {PAIR_W{1'b0}};
                        busy_r     <= 1'b1;
                    end
                end
                ST_ACTIVE: begin
                    if (hs_s) begin
                        pair_cnt_r <= pair_cnt_r + PAIR_W'(1);
                        if (last_col_s) begin
                            col_r     <= {COL_W{1'b0}};
                            row_r     <= row_r + ROW_W'(1);
                            gap_cnt_r <= {GAP_W{1'b0}};
                        end else begin
                            col_r <= col_r + COL_W'(1);
                        end
                    end
                end
                ST_LINE_GAP: gap_cnt_r <= gap_cnt_r + GAP_W'(1);
                ST_DONE:     busy_r    <= 1'b0;
                default:     busy_r    <= 1'b0;
            endcase
        end
    end

    bmp_addr_gen #(
        .IMAGE_WIDTH  (IMAGE_WIDTH),
        .IMAGE_HEIGHT (IMAGE_HEIGHT)
    ) u_addr_gen (
        .clk         (clk),
        .reset       (reset),
        .pair_accept (hs_s),
        .row         (row_r),
        .col         (col_r),
        .wr_en       (wr_en_s),
        .wr_addr     (wr_addr_s)
    );

    assign bus.in_Ready         = in_ready_r;
    assign bus.horizontal_Pulse = hpulse_r;
    assign bus.wr_En            = wr_en_s;
    assign bus.wr_Addr          = wr_addr_s;
    assign bus.pair_Counter     = pair_cnt_r;
    assign bus.busy             = busy_r;
    assign bus.sig_Write_Done   = done_r;

endmodule

// File: tb/tb_bmp_write_scheduler.sv
// Self-checking bench for bmp_write_scheduler: vector table on a 4x2 frame,
// height-1 sequence, and a randomized reference-model run on a 64x40 frame.
module tb_bmp_write_scheduler;

    localparam int AW = 4, AH = 2, AHB = 3;
    localparam int BW = 64, BH = 40, BHB = 5;
    localparam int BTOT = BW * BH / 2;
    localparam int CW = 4, CH = 1, CHB = 3;

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    bmp_write_scheduler_if bif_a ();
    bmp_write_scheduler_if bif_b ();
    bmp_write_scheduler_if bif_c ();

    bmp_write_scheduler #(.IMAGE_WIDTH(AW), .IMAGE_HEIGHT(AH), .HBLANK(AHB))
        u_a (.clk(clk), .reset(reset), .bus(bif_a));
    bmp_write_scheduler #(.IMAGE_WIDTH(BW), .IMAGE_HEIGHT(BH), .HBLANK(BHB))
        u_b (.clk(clk), .reset(reset), .bus(bif_b));
    bmp_write_scheduler #(.IMAGE_WIDTH(CW), .IMAGE_HEIGHT(CH), .HBLANK(CHB))
        u_c (.clk(clk), .reset(reset), .bus(bif_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic start;
        logic valid;
        logic rdy;
        logic hp;
        logic wen;
        int   addr;
        int   pc;
        logic busy;
        logic done;
    } vec_t;

    vec_t tbl[12];

    // Reference address of the k-th accepted pair of a WxH frame.
    function automatic int exp_addr(input int k, input int w, input int h);
        int r, c, ri;
        r = k / (w / 2);
        c = k % (w / 2);
`ifdef BMP_ROW_FLIP_EN
        ri = h - 1 - r;
`else
        ri = r + 0 * h;
`endif
        return (ri * w + 2 * c) * 3;
    endfunction

    function automatic vec_t mk(input logic s, input logic v, input logic r, input logic h,
                                input logic w, input int a, input int p, input logic b,
                                input logic d);
        vec_t t;
        t.start = s; t.valid = v; t.rdy = r; t.hp = h; t.wen = w;
        t.addr = a; t.pc = p; t.busy = b; t.done = d;
        return t;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One full frame on the 64x40 instance against the pair-index reference model.
    task automatic run_b(input bit rnd, input int abort_at, input bit poke);
        int hs_n, wr_n, done_n, last_hs, done_cyc;
        bit prev_hs, hs;
        hs_n = 0; wr_n = 0; done_n = 0; last_hs = -100; done_cyc = -1; prev_hs = 1'b0;
        bif_b.start    = 1'b1;
        bif_b.in_Valid = 1'b0;
        @(negedge clk);
        chk("b_busy_rise", bif_b.busy, 1);
        chk("b_pc_clear", bif_b.pair_Counter, 0);
        for (int cyc = 1; cyc < 10000; cyc++) begin
            bif_b.start = 1'b0;
            chk("b_wr_en", bif_b.wr_En, prev_hs);
            if (bif_b.wr_En) begin
                chk("b_addr", bif_b.wr_Addr, exp_addr(wr_n, BW, BH));
                wr_n++;
                chk("b_pc", bif_b.pair_Counter, wr_n);
                if (poke && wr_n == BTOT) bif_b.start = 1'b1;
            end
            if (bif_b.sig_Write_Done) begin
                done_n++;
                done_cyc = cyc;
                chk("b_done_lat", cyc - last_hs, 2);
                chk("b_done_pairs", hs_n, BTOT);
                chk("b_done_busy", bif_b.busy, 0);
                if (!rnd) chk("b_frame_len", cyc, BTOT + (BH - 1) * BHB + 2);
                if (poke) bif_b.start = 1'b1;
            end
            if (done_cyc >= 0 && cyc >= done_cyc + 4) begin
                chk("b_one_done", done_n, 1);
                chk("b_idle_after", bif_b.busy, 0);
                chk("b_pc_hold", bif_b.pair_Counter, BTOT);
                break;
            end
            if (poke && cyc == 57) bif_b.start = 1'b1;
            bif_b.in_Valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            hs = bif_b.in_Valid && bif_b.in_Ready;
            prev_hs = hs;
            if (hs) begin
                hs_n++;
                last_hs = cyc;
            end
            if (abort_at >= 0 && hs_n == abort_at) begin
                @(negedge clk);
                reset = 1'b0;
                #1;
                chk("rst_ready", bif_b.in_Ready, 0);
                chk("rst_hp", bif_b.horizontal_Pulse, 0);
                chk("rst_wen", bif_b.wr_En, 0);
                chk("rst_addr", bif_b.wr_Addr, 0);
                chk("rst_pc", bif_b.pair_Counter, 0);
                chk("rst_busy", bif_b.busy, 0);
                chk("rst_done", bif_b.sig_Write_Done, 0);
                @(negedge clk);
                reset = 1'b1;
                for (int k = 0; k < 10; k++) begin
                    @(negedge clk);
                    chk("abort_no_done", bif_b.sig_Write_Done, 0);
                    chk("abort_no_wen", bif_b.wr_En, 0);
                end
                bif_b.in_Valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        chk("b_done_seen", done_n, 1);
    endtask

    initial begin
        reset = 1'b0;
        bif_a.start = 1'b0; bif_a.in_Valid = 1'b1;
        bif_b.start = 1'b0; bif_b.in_Valid = 1'b1;
        bif_c.start = 1'b0; bif_c.in_Valid = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Idle with valid held high and no start: nothing may move.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("idle_ready", bif_a.in_Ready, 0);
            chk("idle_wen", bif_a.wr_En, 0);
            chk("idle_addr", bif_a.wr_Addr, 0);
            chk("idle_busy", bif_a.busy, 0);
            chk("idle_done", bif_a.sig_Write_Done, 0);
            chk("idle_b_ready", bif_b.in_Ready, 0);
        end

        // 4x2 frame, HBLANK=3, continuous valid; start re-pulsed in DONE and done cycles.
        tbl[0]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
        tbl[1]  = mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 0, 0, 1'b1, 1'b0);
        tbl[2]  = mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, exp_addr(0, AW, AH), 1, 1'b1, 1'b0);
        tbl[3]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, exp_addr(1, AW, AH), 2, 1'b1, 1'b0);
        tbl[4]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, exp_addr(1, AW, AH), 2, 1'b1, 1'b0);
        tbl[5]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, exp_addr(1, AW, AH), 2, 1'b1, 1'b0);
        tbl[6]  = mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, exp_addr(1, AW, AH), 2, 1'b1, 1'b0);
        tbl[7]  = mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, exp_addr(2, AW, AH), 3, 1'b1, 1'b0);
        tbl[8]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, exp_addr(3, AW, AH), 4, 1'b1, 1'b0);
        tbl[9]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, exp_addr(3, AW, AH), 4, 1'b0, 1'b1);
        tbl[10] = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, exp_addr(3, AW, AH), 4, 1'b0, 1'b0);
        tbl[11] = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, exp_addr(3, AW, AH), 4, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("a%0d_ready", i), bif_a.in_Ready, tbl[i].rdy);
            chk($sformatf("a%0d_hpulse", i), bif_a.horizontal_Pulse, tbl[i].hp);
            chk($sformatf("a%0d_wen", i), bif_a.wr_En, tbl[i].wen);
            chk($sformatf("a%0d_addr", i), bif_a.wr_Addr, tbl[i].addr);
            chk($sformatf("a%0d_pc", i), bif_a.pair_Counter, tbl[i].pc);
            chk($sformatf("a%0d_busy", i), bif_a.busy, tbl[i].busy);
            chk($sformatf("a%0d_done", i), bif_a.sig_Write_Done, tbl[i].done);
            bif_a.start    = tbl[i].start;
            bif_a.in_Valid = tbl[i].valid;
            @(negedge clk);
        end
        bif_a.in_Valid = 1'b0;

        // Single-row frame: straight from the last pair to DONE, no line gap.
        bif_c.start = 1'b1;
        @(negedge clk);
        bif_c.start = 1'b0;
        for (int cyc = 1; cyc < 8; cyc++) begin
            chk("c_wen", bif_c.wr_En, (cyc == 2 || cyc == 3));
            if (bif_c.wr_En) chk("c_addr", bif_c.wr_Addr, exp_addr(cyc - 2, CW, CH));
            chk("c_done", bif_c.sig_Write_Done, (cyc == CW / 2 + 2));
            chk("c_ready", bif_c.in_Ready, (cyc == 1 || cyc == 2));
            @(negedge clk);
        end
        chk("c_pc_final", bif_c.pair_Counter, CW * CH / 2);

        run_b(1'b0, -1, 1'b1);
        run_b(1'b0, 1000, 1'b0);
        run_b(1'b0, -1, 1'b0);
        run_b(1'b1, -1, 1'b0);
        run_b(1'b1, -1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
